slink_rx_pkt_assembler: RTL and testbench
=========================================

Name: slink_rx_pkt_assembler

Overview:
RX-side packet assembler. Takes the byte-serial packet stream from the link layer and drives the S-Link RX application interface (rx_sop/rx_data_id/rx_word_count/rx_app_data/rx_valid/rx_crc_corrupted) that application logic and the app monitor consume. It parses headers, packs long-packet payload into APP_DATA_WIDTH beats and checks the payload CRC. It holds the final beat back until the CRC verdict is known.

Parameters:
APP_DATA_WIDTH, 32, RX application data width in bits. Must be a multiple of 8 and at least 8. NB = APP_DATA_WIDTH/8.

Ports:
link_clk  in  1  link clock
link_reset_n  in  1  asynchronous active-low reset
enable  in  1  block enable; low forces IDLE and quiesces outputs
in_byte  in  8  packet byte from link layer
in_valid  in  1  in_byte valid; at most one byte per cycle
in_sop  in  1  first byte (data ID) of a packet; qualified by in_valid
rx_sop  out  1  first beat of a packet
rx_data_id  out  8  data ID; valid while rx_valid
rx_word_count  out  16  word count / short-packet payload; valid while rx_valid
rx_app_data  out  APP_DATA_WIDTH  payload, byte 0 in bits [7:0]
rx_valid  out  1  beat valid (one-cycle pulse per beat)
rx_crc_corrupted  out  1  CRC mismatch; asserted only with the final beat of a long packet
rx_abort  out  1  one-cycle pulse when an in-progress packet is discarded

Behaviour:
- Reset and enable=0 clear all outputs to 0, clear the state to IDLE, clear the CRC to 0xFFFF and clear the counters.
- Packet format on input:
  - Header is DI, WC[7:0], WC[15:8], ECC. The ECC byte is consumed and not checked.
  - DI <= 0x1F is a short packet: header only.
  - DI > 0x1F is a long packet: header, then WC payload bytes, then CRC[7:0], then CRC[15:8].
- CRC: CRC-16, reflected poly 0x8408, init 0xFFFF, no final XOR, computed over payload bytes only. Mismatch means the computed value != the received {hi,lo}.
- States:
  - IDLE: on in_valid&in_sop, capture DI and go to HDR. Valid bytes without sop are dropped silently.
  - HDR: capture WC lo, then WC hi, then ECC. After ECC:
    - short packet: register an output beat and go to IDLE.
    - long packet, WC>0: go to PAYLOAD.
    - long packet, WC=0: go to CRC_LO.
  - PAYLOAD: write the byte into lane (byte_idx mod NB) and decrement remaining.
    - If the lane fills and remaining>0, register a beat. rx_sop is set only on the first beat of the packet.
    - When remaining reaches 0, hold the partial word and go to CRC_LO.
  - CRC_LO, then CRC_HI: on CRC_HI, register the final beat with rx_crc_corrupted set to the mismatch flag, then go to IDLE.
- Final-beat field values:
  - The final beat carries rx_sop=1 if it is the only beat (WC <= NB, including WC=0).
  - Unused lanes of a partial word are zero. For WC=0 the final beat data is all zero.
- Beat field values:
  - rx_data_id and rx_word_count hold the packet values on every beat of that packet.
  - For short packets, rx_app_data = 0.
- Latency: an output beat appears on the cycle after the input byte that completes it (the word-filling payload byte, ECC for short packets, CRC hi for final beats).
- Outputs are registered. rx_valid and rx_abort are single-cycle pulses.
- There is no backpressure. A downstream stall is not permitted, and input rate guarantees no overrun.
- in_valid=0 cycles within a packet are gaps: state holds, no effect.
- in_valid&in_sop in any state other than IDLE:
  - pulse rx_abort and discard the partial packet, emitting no further beats for it.
  - treat the byte as the DI of a new packet and go to HDR.
- enable deasserted mid-packet: no abort pulse, immediate drop.
- Asynchronous reset mid-packet: immediate return to IDLE with outputs 0.
- rx_sop is never asserted without rx_valid.

Test Plan:
- Short packet DI=0x05, WC=0xBEEF, ECC=0x00 -> one cycle later: rx_sop=1, rx_valid=1, rx_data_id=0x05, rx_word_count=0xBEEF, rx_app_data=0; no further beats.
- Long packet DI=0x40, WC=8, payload 01..08, correct CRC -> beat 1 (rx_sop=1) data 0x04030201; beat 2 on the cycle after CRC hi, data 0x08070605, rx_crc_corrupted=0.
- Same packet with CRC hi byte flipped -> identical beats, except the final beat has rx_crc_corrupted=1.
- Long packet DI=0x22, WC=5, payload AA..EE -> beat 1 0xDDCCBBAA (rx_sop=1); final beat 0x000000EE.
- Long packet DI=0x22, WC=0, CRC bytes FF,FF -> single beat, rx_sop=1, data 0, rx_crc_corrupted=0.
- Abort and reset: new in_sop after 3 payload bytes of a WC=8 packet -> rx_abort pulses, no beats for the old packet, new packet decodes correctly. Assert link_reset_n low mid-payload -> all outputs 0 asynchronously, and the next packet decodes cleanly.

Source files
------------

// File: rtl/slink_rx_pkt_assembler_if.sv
// S-Link RX packet assembler bus.
// Groups the byte-serial link-layer input and the RX application output of
// slink_rx_pkt_assembler into one bundle.
//   in_byte/in_valid/in_sop  : link layer -> assembler, one byte per cycle max
//   rx_sop/rx_data_id/rx_word_count/rx_app_data/rx_valid/rx_crc_corrupted
//                            : assembler -> application, one beat per pulse
//   rx_abort                 : assembler -> application, discarded-packet pulse
// The slave modport is the assembler's view; master is the surrounding logic.
interface slink_rx_pkt_assembler_if #(
  parameter int APP_DATA_WIDTH = 32
);
  logic [7:0]                in_byte;
  logic                      in_valid;
  logic                      in_sop;
  logic                      rx_sop;
  logic [7:0]                rx_data_id;
  logic [15:0]               rx_word_count;
  logic [APP_DATA_WIDTH-1:0] rx_app_data;
  logic                      rx_valid;
  logic                      rx_crc_corrupted;
  logic                      rx_abort;

  modport slave (
    input  in_byte, in_valid, in_sop,
    output rx_sop, rx_data_id, rx_word_count, rx_app_data,
           rx_valid, rx_crc_corrupted, rx_abort
  );

  modport master (
    output in_byte, in_valid, in_sop,
    input  rx_sop, rx_data_id, rx_word_count, rx_app_data,
           rx_valid, rx_crc_corrupted, rx_abort
  );
endinterface

// File: rtl/slink_rx_pkt_assembler.sv
// S-Link RX packet assembler.
// Parses the byte-serial packet stream (DI, WC lo, WC hi, ECC, then for long
// packets WC payload bytes and CRC lo/hi), packs payload into
// APP_DATA_WIDTH-bit beats and checks the CRC-16 (reflected 0x8408, init
// 0xFFFF, no final XOR) over the payload. The last beat of a long packet is
// held until the CRC verdict is known.
// Ports:
//   link_clk      : clock
//   link_reset_n  : asynchronous active-low reset
//   enable        : low forces IDLE and clears all outputs (no abort pulse)
//   bus (slave)   : in_byte/in_valid/in_sop input, rx_* application output
module slink_rx_pkt_assembler #(
  parameter int APP_DATA_WIDTH = 32
) (
  input logic                     link_clk,
  input logic                     link_reset_n,
  input logic                     enable,
  slink_rx_pkt_assembler_if.slave bus
);

  localparam int NB = APP_DATA_WIDTH / 8;
  localparam int LW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CRC_LO  = 3'd3,
    ST_CRC_HI  = 3'd4
  } state_t;

  // One byte step of the reflected CRC-16.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  // Packet tracking state
  state_t                    state_q,   state_d;
  logic [7:0]                di_q,      di_d;
  logic [15:0]               wc_q,      wc_d;
  logic [1:0]                hdr_cnt_q, hdr_cnt_d;
  logic [15:0]               rem_q,     rem_d;
  logic [LW-1:0]             lane_q,    lane_d;
  logic [APP_DATA_WIDTH-1:0] word_q,    word_d;
  logic                      first_q,   first_d;
  logic [15:0]               crc_q,     crc_d;
  logic [7:0]                crc_lo_q,  crc_lo_d;

  // Registered outputs
  logic                      rx_sop_q,   rx_sop_d;
  logic [7:0]                rx_di_q,    rx_di_d;
  logic [15:0]               rx_wc_q,    rx_wc_d;
  logic [APP_DATA_WIDTH-1:0] rx_data_q,  rx_data_d;
  logic                      rx_valid_q, rx_valid_d;
  logic                      rx_crc_q,   rx_crc_d;
  logic                      rx_abort_q, rx_abort_d;

  // Word with the current byte merged into its lane, and the decremented count.
  logic [APP_DATA_WIDTH-1:0] word_fill;
  logic [15:0]               rem_dec;
  logic                      lane_full;

  always_comb begin
    word_fill = word_q;
    for (int i = 0; i < NB; i++) begin
      if (lane_q == LW'(i)) begin
        word_fill[i*8 +: 8] = bus.in_byte;
      end
    end
  end

  assign rem_dec   = rem_q - 16'd1;
  assign lane_full = (lane_q == LW'(NB - 1));

  always_ff @(posedge link_clk or negedge link_reset_n) begin
    if (!link_reset_n) begin
      state_q    <= ST_IDLE;
      di_q       <= '0;
      wc_q       <= '0;
      hdr_cnt_q  <= '0;
      rem_q      <= '0;
      lane_q     <= '0;
      word_q     <= '0;
      first_q    <= 1'b0;
      crc_q      <= 16'hFFFF;
      crc_lo_q   <= '0;
      rx_sop_q   <= 1'b0;
      rx_di_q    <= '0;
      rx_wc_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_crc_q   <= 1'b0;
      rx_abort_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      di_q       <= di_d;
      wc_q       <= wc_d;
      hdr_cnt_q  <= hdr_cnt_d;
      rem_q      <= rem_d;
      lane_q     <= lane_d;
      word_q     <= word_d;
      first_q    <= first_d;
      crc_q      <= crc_d;
      crc_lo_q   <= crc_lo_d;
      rx_sop_q   <= rx_sop_d;
      rx_di_q    <= rx_di_d;
      rx_wc_q    <= rx_wc_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_crc_q   <= rx_crc_d;
      rx_abort_q <= rx_abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    di_d       = di_q;
    wc_d       = wc_q;
    hdr_cnt_d  = hdr_cnt_q;
    rem_d      = rem_q;
    lane_d     = lane_q;
    word_d     = word_q;
    first_d    = first_q;
    crc_d      = crc_q;
    crc_lo_d   = crc_lo_q;
    rx_sop_d   = 1'b0;
    rx_valid_d = 1'b0;
    rx_crc_d   = 1'b0;
    rx_abort_d = 1'b0;
    rx_di_d    = rx_di_q;
    rx_wc_d    = rx_wc_q;
    rx_data_d  = rx_data_q;

    if (!enable) begin
      state_d   = ST_IDLE;
      di_d      = '0;
      wc_d      = '0;
      hdr_cnt_d = '0;
      rem_d     = '0;
      lane_d    = '0;
      word_d    = '0;
      first_d   = 1'b0;
      crc_d     = 16'hFFFF;
      crc_lo_d  = '0;
      rx_di_d   = '0;
      rx_wc_d   = '0;
      rx_data_d = '0;
    end else if (bus.in_valid && bus.in_sop) begin
      // A DI byte always starts a fresh packet; anything in flight is dropped.
      rx_abort_d = (state_q != ST_IDLE);
      di_d       = bus.in_byte;
      wc_d       = '0;
      hdr_cnt_d  = '0;
      rem_d      = '0;
      lane_d     = '0;
      word_d     = '0;
      first_d    = 1'b1;
      crc_d      = 16'hFFFF;
      state_d    = ST_HDR;
    end else if (bus.in_valid) begin
      case (state_q)
        ST_IDLE: begin
          // Stray bytes outside a packet are ignored.
        end

        ST_HDR: begin
          case (hdr_cnt_q)
            2'd0: begin
              wc_d[7:0] = bus.in_byte;
              hdr_cnt_d = 2'd1;
            end
            2'd1: begin
              wc_d[15:8] = bus.in_byte;
              hdr_cnt_d  = 2'd2;
            end
            default: begin
              // ECC byte: consumed, not checked.
              hdr_cnt_d = 2'd0;
              if (di_q <= 8'h1F) begin
                rx_valid_d = 1'b1;
                rx_sop_d   = 1'b1;
                rx_di_d    = di_q;
                rx_wc_d    = wc_q;
                rx_data_d  = '0;
                state_d    = ST_IDLE;
              end else if (wc_q != 16'd0) begin
                rem_d   = wc_q;
                state_d = ST_PAYLOAD;
              end else begin
                state_d = ST_CRC_LO;
              end
            end
          endcase
        end

        ST_PAYLOAD: begin
          crc_d  = crc16_byte(crc_q, bus.in_byte);
          rem_d  = rem_dec;
          word_d = word_fill;
          if (rem_dec == 16'd0) begin
            // Last payload byte: keep the (possibly full) word for the final
            // beat, which waits for the CRC verdict.
            state_d = ST_CRC_LO;
          end else if (lane_full) begin
            rx_valid_d = 1'b1;
            rx_sop_d   = first_q;
            rx_di_d    = di_q;
            rx_wc_d    = wc_q;
            rx_data_d  = word_fill;
            first_d    = 1'b0;
            word_d     = '0;
            lane_d     = '0;
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end

        ST_CRC_LO: begin
          crc_lo_d = bus.in_byte;
          state_d  = ST_CRC_HI;
        end

        ST_CRC_HI: begin
          rx_valid_d = 1'b1;
          rx_sop_d   = first_q;
          rx_di_d    = di_q;
          rx_wc_d    = wc_q;
          rx_data_d  = word_q;
          rx_crc_d   = (crc_q != {bus.in_byte, crc_lo_q});
          state_d    = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rx_sop           = rx_sop_q;
  assign bus.rx_data_id       = rx_di_q;
  assign bus.rx_word_count    = rx_wc_q;
  assign bus.rx_app_data      = rx_data_q;
  assign bus.rx_valid         = rx_valid_q;
  assign bus.rx_crc_corrupted = rx_crc_q;
  assign bus.rx_abort         = rx_abort_q;

endmodule

// File: tb/tb_slink_rx_pkt_assembler.sv
module tb_slink_rx_pkt_assembler;

  localparam int W = 32;

  logic link_clk;
  logic link_reset_n;
  logic enable;

  slink_rx_pkt_assembler_if #(.APP_DATA_WIDTH(W)) bus ();

  slink_rx_pkt_assembler #(.APP_DATA_WIDTH(W)) dut (
    .link_clk     (link_clk),
    .link_reset_n (link_reset_n),
    .enable       (enable),
    .bus          (bus)
  );

  initial link_clk = 1'b0;
  always #5 link_clk = ~link_clk;

  typedef struct packed {
    logic        sop;
    logic [7:0]  di;
    logic [15:0] wc;
    logic [W-1:0] data;
    logic        crc;
  } beat_t;

  beat_t      mon_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] pay [16];

  // Capture every beat, sampled mid-cycle.
  always @(negedge link_clk) begin
    if (bus.rx_valid) begin
      mon_q.push_back({bus.rx_sop, bus.rx_data_id, bus.rx_word_count,
                       bus.rx_app_data, bus.rx_crc_corrupted});
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  function automatic logic [15:0] crc16(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {8'h00, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    return c;
  endfunction

  // Called at a negedge; presents the byte for the next posedge and returns
  // at the following negedge, when the registered response is visible.
  task automatic send(input logic [7:0] b, input logic sop);
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    bus.in_sop   = sop;
    @(negedge link_clk);
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge link_clk);
  endtask

  task automatic send_hdr(input logic [7:0] di, input logic [15:0] wc);
    send(di, 1'b1);
    send(wc[7:0], 1'b0);
    send(wc[15:8], 1'b0);
    send(8'h00, 1'b0);
  endtask

  task automatic send_long_raw(input string tag, input logic [7:0] di, input logic [15:0] wc,
                               input logic [7:0] lo, input logic [7:0] hi, input int gap);
    send_hdr(di, wc);
    for (int i = 0; i < int'(wc); i++) begin
      send(pay[i], 1'b0);
      idle(gap);
    end
    send(lo, 1'b0);
    send(hi, 1'b0);
    check({tag, " final latency"}, 64'(bus.rx_valid), 64'd1);
  endtask

  task automatic send_long(input string tag, input logic [7:0] di, input logic [15:0] wc,
                           input logic [7:0] hi_flip, input int gap);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < int'(wc); i++) c = crc16(c, pay[i]);
    send_long_raw(tag, di, wc, c[7:0], c[15:8] ^ hi_flip, gap);
  endtask

  task automatic expect_beat(input string tag, input logic sop, input logic [7:0] di,
                             input logic [15:0] wc, input logic [W-1:0] data, input logic crc);
    beat_t b;
    if (mon_q.size() == 0) begin
      check({tag, " present"}, 64'd0, 64'd1);
    end else begin
      b = mon_q.pop_front();
      check({tag, " sop"},  64'(b.sop),  64'(sop));
      check({tag, " di"},   64'(b.di),   64'(di));
      check({tag, " wc"},   64'(b.wc),   64'(wc));
      check({tag, " data"}, 64'(b.data), 64'(data));
      check({tag, " crc"},  64'(b.crc),  64'(crc));
    end
  endtask

  task automatic expect_none(input string tag);
    check({tag, " extra beats"}, 64'(mon_q.size()), 64'd0);
    mon_q.delete();
  endtask

  initial begin
    link_reset_n = 1'b0;
    enable       = 1'b1;
    bus.in_byte  = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    idle(3);
    check("reset rx_valid", 64'(bus.rx_valid), 64'd0);
    check("reset rx_sop",   64'(bus.rx_sop),   64'd0);
    check("reset rx_abort", 64'(bus.rx_abort), 64'd0);
    check("reset rx_data",  64'(bus.rx_app_data), 64'd0);
    link_reset_n = 1'b1;
    idle(1);

    // Bytes without sop while idle are dropped.
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    idle(3);
    expect_none("drop");

    // Short packet.
    send_hdr(8'h05, 16'hBEEF);
    check("short latency", 64'(bus.rx_valid), 64'd1);
    idle(3);
    expect_beat("short", 1'b1, 8'h05, 16'hBEEF, 32'h0, 1'b0);
    expect_none("short");

    // Long WC=8, good CRC.
    for (int i = 0; i < 8; i++) pay[i] = 8'(i + 1);
    send_long("l8", 8'h40, 16'd8, 8'h00, 0);
    idle(2);
    expect_beat("l8 b1", 1'b1, 8'h40, 16'd8, 32'h04030201, 1'b0);
    expect_beat("l8 b2", 1'b0, 8'h40, 16'd8, 32'h08070605, 1'b0);
    expect_none("l8");

    // Same packet, CRC hi byte flipped.
    send_long("l8bad", 8'h40, 16'd8, 8'hFF, 0);
    idle(2);
    expect_beat("l8bad b1", 1'b1, 8'h40, 16'd8, 32'h04030201, 1'b0);
    expect_beat("l8bad b2", 1'b0, 8'h40, 16'd8, 32'h08070605, 1'b1);
    expect_none("l8bad");

    // WC=5 partial final word, with input gaps between payload bytes.
    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC; pay[3] = 8'hDD; pay[4] = 8'hEE;
    send_long("l5", 8'h22, 16'd5, 8'h00, 2);
    idle(2);
    expect_beat("l5 b1", 1'b1, 8'h22, 16'd5, 32'hDDCCBBAA, 1'b0);
    expect_beat("l5 b2", 1'b0, 8'h22, 16'd5, 32'h000000EE, 1'b0);
    expect_none("l5");

    // WC=0: empty-payload CRC is the init value 0xFFFF.
    send_long_raw("l0", 8'h22, 16'd0, 8'hFF, 8'hFF, 0);
    idle(2);
    expect_beat("l0", 1'b1, 8'h22, 16'd0, 32'h0, 1'b0);
    expect_none("l0");

    // WC=9 "123456789": CRC value of this algorithm is 0x6F91.
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    send_long_raw("l9", 8'h30, 16'd9, 8'h91, 8'h6F, 0);
    idle(2);
    expect_beat("l9 b1", 1'b1, 8'h30, 16'd9, 32'h34333231, 1'b0);
    expect_beat("l9 b2", 1'b0, 8'h30, 16'd9, 32'h38373635, 1'b0);
    expect_beat("l9 b3", 1'b0, 8'h30, 16'd9, 32'h00000039, 1'b0);
    expect_none("l9");

    // Abort: new sop after 3 payload bytes of a WC=8 packet.
    send_hdr(8'h40, 16'd8);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h05, 1'b1);
    check("abort pulse", 64'(bus.rx_abort), 64'd1);
    send(8'h34, 1'b0);
    check("abort single cycle", 64'(bus.rx_abort), 64'd0);
    send(8'h12, 1'b0);
    send(8'h00, 1'b0);
    idle(3);
    expect_beat("after abort", 1'b1, 8'h05, 16'h1234, 32'h0, 1'b0);
    expect_none("after abort");

    // Asynchronous reset while a beat is on the outputs.
    send_hdr(8'h40, 16'd8);
    for (int i = 0; i < 4; i++) send(8'(i + 1), 1'b0);
    check("rst pre valid", 64'(bus.rx_valid), 64'd1);
    #2 link_reset_n = 1'b0;
    #1;
    check("rst async valid", 64'(bus.rx_valid), 64'd0);
    check("rst async sop",   64'(bus.rx_sop),   64'd0);
    check("rst async di",    64'(bus.rx_data_id), 64'd0);
    check("rst async data",  64'(bus.rx_app_data), 64'd0);
    @(posedge link_clk);
    #2 link_reset_n = 1'b1;
    @(negedge link_clk);
    mon_q.delete();
    for (int i = 4; i < 8; i++) send(8'(i + 1), 1'b0);
    send_hdr(8'h07, 16'h0102);
    idle(3);
    expect_beat("post reset", 1'b1, 8'h07, 16'h0102, 32'h0, 1'b0);
    expect_none("post reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
